// File: rtl/pw_requant_serializer.sv
// pw_requant_serializer: captures one vector of pointwise-conv accumulators,
// requantizes each channel and streams one activation per valid/ready beat.
module pw_requant_serializer #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int OUT_CH  = 8,
    parameter int MULT_W  = 16,
    parameter int SHIFT_W = 6
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_valid,
    input  logic [OUT_CH*ACC_W-1:0]   i_vec_flat,
    input  logic [OUT_CH*ACC_W-1:0]   i_bias_flat,
    input  logic [OUT_CH*MULT_W-1:0]  i_mult_flat,
    input  logic [SHIFT_W-1:0]        i_shift,
    input  logic                      i_relu_en,
    output logic                      o_ready_in,
    output logic                      o_drop,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [DATA_W-1:0]         o_data,
    output logic [$clog2(OUT_CH)-1:0] o_ch,
    output logic                      o_last
);
    localparam int CW = $clog2(OUT_CH);
    localparam int PW = ACC_W + 1 + MULT_W;
    localparam int EW = PW + 1;
    localparam logic signed [EW-1:0] SMAX = EW'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [EW-1:0] SMIN = ~SMAX;

    typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

    state_t                  state;
    logic [OUT_CH*ACC_W-1:0] vec_r;
    logic [SHIFT_W-1:0]      shift_r;
    logic                    relu_r;
    logic [CW-1:0]           cnt;

    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  bias;
    logic signed [MULT_W-1:0] mult;
    logic signed [ACC_W:0]    sum;
    logic signed [PW-1:0]     prod;
    logic signed [EW-1:0]     rnd;
    logic signed [EW-1:0]     res;
    logic [DATA_W-1:0]        q;

    always_comb begin
        acc  = vec_r[int'(cnt)*ACC_W +: ACC_W];
        bias = i_bias_flat[int'(cnt)*ACC_W +: ACC_W];
        mult = i_mult_flat[int'(cnt)*MULT_W +: MULT_W];
        sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(bias);
        prod = PW'(sum) * PW'(mult);
        rnd  = '0;
        if (shift_r != '0 && int'(shift_r) < PW)
            rnd = EW'(1) << (shift_r - 1'b1);
        res = (EW'(prod) + rnd) >>> shift_r;
        // shifting past the product width always rounds to zero
        if (int'(shift_r) >= PW)
            res = '0;
        if (relu_r && res[EW-1])
            res = '0;
        if (res > SMAX)
            q = SMAX[DATA_W-1:0];
        else if (res < SMIN)
            q = SMIN[DATA_W-1:0];
        else
            q = res[DATA_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vec_r      <= '0;
            shift_r    <= '0;
            relu_r     <= 1'b0;
            cnt        <= '0;
            o_ready_in <= 1'b1;
            o_drop     <= 1'b0;
            o_valid    <= 1'b0;
            o_data     <= '0;
            o_ch       <= '0;
            o_last     <= 1'b0;
        end else begin
            if (i_valid && state != IDLE)
                o_drop <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (i_valid) begin
                        vec_r      <= i_vec_flat;
                        shift_r    <= i_shift;
                        relu_r     <= i_relu_en;
                        cnt        <= '0;
                        o_ready_in <= 1'b0;
                        state      <= MUL;
                    end
                end
                MUL: begin
                    o_data  <= q;
                    o_ch    <= cnt;
                    o_last  <= (cnt == CW'(OUT_CH - 1));
                    o_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        if (o_last) begin
                            o_ready_in <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= MUL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pw_requant_serializer.sv
// Scoreboard bench for pw_requant_serializer: random vectors, an arithmetic
// reference model, and a negedge monitor popping expected beats.
module tb_pw_requant_serializer;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;
    localparam int OUT_CH  = 8;
    localparam int MULT_W  = 16;
    localparam int SHIFT_W = 6;
    localparam int CW      = $clog2(OUT_CH);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic i_valid = 1'b0;
    logic i_relu_en = 1'b0;
    logic i_ready = 1'b1;
    logic [OUT_CH*ACC_W-1:0] i_vec_flat = '0;
    logic [OUT_CH*ACC_W-1:0] i_bias_flat = '0;
    logic [OUT_CH*MULT_W-1:0] i_mult_flat = '0;
    logic [SHIFT_W-1:0] i_shift = '0;
    logic o_ready_in, o_drop, o_valid, o_last;
    logic [DATA_W-1:0] o_data;
    logic [CW-1:0] o_ch;

    always #5 clk = ~clk;

    pw_requant_serializer #(
        .DATA_W(DATA_W), .ACC_W(ACC_W), .OUT_CH(OUT_CH),
        .MULT_W(MULT_W), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
        .i_vec_flat(i_vec_flat), .i_bias_flat(i_bias_flat),
        .i_mult_flat(i_mult_flat), .i_shift(i_shift),
        .i_relu_en(i_relu_en), .o_ready_in(o_ready_in),
        .o_drop(o_drop), .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_ch(o_ch), .o_last(o_last)
    );

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CW-1:0]     ch;
        logic              last;
    } beat_t;

    beat_t   exp_q[$];
    beat_t   e;
    beat_t   prev;
    logic    prev_stall = 1'b0;
    int      checks = 0;
    int      failures = 0;
    int      ready_mode = 0;
    int      stall_left = 0;
    int      acc_a[OUT_CH];
    int      bias_a[OUT_CH];
    shortint mult_a[OUT_CH];

    function automatic logic [DATA_W-1:0] model(input int acc, input int bias,
                                                input shortint mult, input int sh,
                                                input bit relu);
        longint p;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (DATA_W - 1)) - 1;
        lo = -(longint'(1) <<< (DATA_W - 1));
        p = (longint'(acc) + longint'(bias)) * longint'(mult);
        if (sh > 0)
            p = p + (longint'(1) <<< (sh - 1));
        p = p >>> sh;
        if (relu && p < 0) p = 0;
        if (p > hi) p = hi;
        if (p < lo) p = lo;
        return p[DATA_W-1:0];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out", name);
    endtask

    // Monitor: pops on each handshake and checks beats hold under backpressure.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!o_valid || {o_data, o_ch, o_last} !== prev) begin
                    failures++;
                    $display("FAIL hold: got v=%0b data=%0d ch=%0d expected data=%0d ch=%0d",
                             o_valid, $signed(o_data), o_ch, $signed(prev.data), prev.ch);
                end
            end
            if (o_valid && i_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL beat: unexpected beat data=%0d ch=%0d", $signed(o_data), o_ch);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_data, o_ch, o_last} !== e) begin
                        failures++;
                        $display("FAIL beat: got data=%0d ch=%0d last=%0b expected data=%0d ch=%0d last=%0b",
                                 $signed(o_data), o_ch, o_last, $signed(e.data), e.ch, e.last);
                    end
                end
            end
            prev_stall = o_valid && !i_ready;
            prev = {o_data, o_ch, o_last};
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: i_ready = 1'($urandom_range(0, 1));
            2: begin
                if (o_valid && o_ch == CW'(3) && stall_left > 0) begin
                    i_ready = 1'b0;
                    stall_left--;
                end else begin
                    i_ready = 1'b1;
                end
            end
            default: i_ready = 1'b1;
        endcase
    end

    task automatic fill_const(input int acc, input int bias, input shortint mult);
        for (int c = 0; c < OUT_CH; c++) begin
            acc_a[c] = acc;
            bias_a[c] = bias;
            mult_a[c] = mult;
        end
    endtask

    task automatic fill_rand();
        for (int c = 0; c < OUT_CH; c++) begin
            acc_a[c] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                   : int'($urandom_range(0, 4000)) - 2000;
            bias_a[c] = ($urandom_range(0, 3) == 0) ? int'($urandom)
                                                    : int'($urandom_range(0, 400)) - 200;
            mult_a[c] = ($urandom_range(0, 3) == 0) ? shortint'($urandom)
                                                    : shortint'(int'($urandom_range(0, 600)) - 300);
        end
    endtask

    function automatic int rand_shift();
        return ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                           : int'($urandom_range(0, 12));
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the capture edge.
    task automatic send(input int sh, input bit relu);
        int n;
        n = 0;
        while (!o_ready_in && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!o_ready_in) timeout("send_wait_ready");
        for (int c = 0; c < OUT_CH; c++) begin
            i_vec_flat[c*ACC_W +: ACC_W] = acc_a[c];
            i_bias_flat[c*ACC_W +: ACC_W] = bias_a[c];
            i_mult_flat[c*MULT_W +: MULT_W] = mult_a[c];
            exp_q.push_back({model(acc_a[c], bias_a[c], mult_a[c], sh, relu),
                             CW'(c), c == OUT_CH - 1});
        end
        i_shift = SHIFT_W'(sh);
        i_relu_en = relu;
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic pulse_garbage();
        i_vec_flat = {OUT_CH{32'hdead_beef}};
        i_shift = SHIFT_W'($urandom);
        i_relu_en = 1'($urandom);
        i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && o_ready_in) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) timeout("wait_idle");
    endtask

    task automatic wait_beat(input int ch, input bit want_last);
        int n;
        n = 0;
        while (!(o_valid && int'(o_ch) == ch && (!want_last || o_last)) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) timeout("wait_beat");
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 0);
        check("rst_ch", o_ch, 0);
        check("rst_last", o_last, 0);
        check("rst_drop", o_drop, 0);
        check("rst_ready_in", o_ready_in, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        fill_const(100, 0, 3);
        send(2, 0);
        check("mul_cycle_valid", o_valid, 0);
        check("busy_ready_in", o_ready_in, 0);
        @(posedge clk); #1;
        check("first_beat_latency", o_valid, 1);
        n = 1;
        while (!o_ready_in && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_in_return_edges", n, 16);

        fill_const(-100, 0, 3);
        send(2, 0);
        send(2, 1);
        fill_const(1000, 24, 1);
        send(3, 0);
        fill_const(-1000, 0, 1);
        send(0, 0);
        fill_const(32'h7fff_ffff, 32'h7fff_ffff, 16'sh7fff);
        send(0, 0);
        wait_idle();

        ready_mode = 2;
        stall_left = 5;
        fill_rand();
        send(rand_shift(), 1'($urandom));
        wait_idle();
        check("stall_consumed", stall_left, 0);
        ready_mode = 1;
        for (int v = 0; v < 4; v++) begin
            fill_rand();
            send(rand_shift(), 1'($urandom));
            wait_idle();
        end
        ready_mode = 0;
        @(posedge clk); #1;

        fill_rand();
        send(rand_shift(), 0);
        wait_beat(2, 0);
        pulse_garbage();
        check("overrun_drop", o_drop, 1);
        wait_idle();
        check("drop_sticky", o_drop, 1);
        check("idle_ready_in", o_ready_in, 1);
        fill_rand();
        send(rand_shift(), 1);
        wait_idle();
        check("drop_sticky_after", o_drop, 1);

        fill_rand();
        send(rand_shift(), 0);
        wait_beat(4, 0);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_drop", o_drop, 0);
        check("midrst_ready_in", o_ready_in, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_rand();
        send(rand_shift(), 0);
        wait_idle();
        check("drop_clear_after_rst", o_drop, 0);

        fill_rand();
        send(rand_shift(), 0);
        wait_beat(OUT_CH - 1, 1);
        pulse_garbage();
        check("final_hs_drop", o_drop, 1);
        wait_idle();

        ready_mode = 1;
        for (int v = 0; v < 10; v++) begin
            fill_rand();
            send(rand_shift(), 1'($urandom));
        end
        wait_idle();
        ready_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("end_valid", o_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
